instr_sequencer: RTL and testbench

Control sequencer directly downstream of the 8-bit program counter. It consumes the current pc, fetches the 16-bit instruction from synchronous instruction memory, and decodes it. It dispatches datapath ops via a start/done handshake. It then drives the pc's branch/branchaddress/done inputs to advance or redirect fetch. It also handles HALT, stall, and an exec-timeout fault.

---
 rtl/instr_sequencer.sv | 171 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/dispatch controller sitting after the 8-bit
// program counter. Fetches from synchronous imem, launches datapath ops via a
// start/done handshake and tells the pc to either increment or branch.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_FETCH    | present pc to imem (held off while stall=1)
// S_WAIT     | imem read in flight; word captured into ir at end of cycle
// S_DISPATCH | decode opcode; launch datapath op for opcodes 4..15
// S_EXEC     | wait for exec_done, bounded by TIMEOUT cycles
// S_COMMIT   | single-cycle branch or done pulse to the pc
// S_HALT     | stopped after HALT opcode or exec timeout; only rst exits
module instr_sequencer #(
    parameter int IW      = 16,
    parameter int AW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc,
    input  logic          stall,
    output logic          imem_rd,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_data,
    output logic          exec_start,
    output logic [3:0]    exec_op,
    input  logic          exec_done,
    input  logic          exec_zero,
    output logic          branch,
    output logic [AW-1:0] branchaddress,
    output logic          done,
    output logic          halted,
    output logic          fault
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_DISPATCH,
        S_EXEC,
        S_COMMIT,
        S_HALT
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    ir_op;
    logic [AW-1:0] ir_tgt;
    logic          zero_flag, zero_nxt;
    logic [7:0]    cnt, cnt_nxt;
    logic          fault_q, fault_nxt;
    logic          commit_br, commit_br_nxt;

    // Instruction bits between the opcode and the target field carry no meaning.
    logic unused_bits;
    assign unused_bits = ^imem_data[IW-5:AW];

    // State and control registers; reset aborts any in-flight op at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            zero_flag <= 1'b0;
            cnt       <= '0;
            fault_q   <= 1'b0;
            commit_br <= 1'b0;
        end else begin
            state     <= state_nxt;
            zero_flag <= zero_nxt;
            cnt       <= cnt_nxt;
            fault_q   <= fault_nxt;
            commit_br <= commit_br_nxt;
        end
    end

    // Instruction register, loaded from imem the cycle after the read strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_op  <= '0;
            ir_tgt <= '0;
        end else if (state == S_WAIT) begin
            ir_op  <= imem_data[IW-1:IW-4];
            ir_tgt <= imem_data[AW-1:0];
        end
    end

    // Next-state decode and all outputs as a function of the current state.
    always_comb begin
        state_nxt     = state;
        zero_nxt      = zero_flag;
        cnt_nxt       = cnt;
        fault_nxt     = fault_q;
        commit_br_nxt = commit_br;
        imem_rd       = 1'b0;
        imem_addr     = '0;
        exec_start    = 1'b0;
        exec_op       = 4'd0;
        branch        = 1'b0;
        branchaddress = '0;
        done          = 1'b0;
        halted        = 1'b0;

        case (state)
            S_FETCH: begin
                // rst forces state to FETCH asynchronously; keep the strobe quiet while it is held
                if (!stall && !rst) begin
                    imem_rd   = 1'b1;
                    imem_addr = pc;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                state_nxt = S_DISPATCH;
            end
            S_DISPATCH: begin
                case (ir_op)
                    4'd0: begin
                        commit_br_nxt = 1'b0;
                        state_nxt     = S_COMMIT;
                    end
                    4'd1: begin
                        commit_br_nxt = 1'b1;
                        state_nxt     = S_COMMIT;
                    end
                    4'd2: begin
                        commit_br_nxt = zero_flag;
                        state_nxt     = S_COMMIT;
                    end
                    4'd3: begin
                        state_nxt = S_HALT;
                    end
                    default: begin
                        exec_start = 1'b1;
                        exec_op    = ir_op;
                        cnt_nxt    = '0;
                        state_nxt  = S_EXEC;
                    end
                endcase
            end
            S_EXEC: begin
                exec_op = ir_op;
                cnt_nxt = cnt + 8'd1;
                // A completion in the final allowed cycle still wins over the fault.
                if (exec_done) begin
                    zero_nxt      = exec_zero;
                    commit_br_nxt = 1'b0;
                    state_nxt     = S_COMMIT;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    fault_nxt = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            S_COMMIT: begin
                if (commit_br) begin
                    branch        = 1'b1;
                    branchaddress = ir_tgt;
                end else begin
                    done = 1'b1;
                end
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    assign fault = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a small program in a behavioural imem,
// a behavioural pc, and hand-computed checks at each negative clock edge.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pc;
    logic        stall;
    logic        imem_rd;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        exec_start;
    logic [3:0]  exec_op;
    logic        exec_done;
    logic        exec_zero;
    logic        branch;
    logic [7:0]  branchaddress;
    logic        done;
    logic        halted;
    logic        fault;

    logic [15:0] mem [0:255];
    logic [7:0]  pc_init;
    logic        pc_init_en;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    logic saw_pulse;

    instr_sequencer #(.IW(16), .AW(8), .TIMEOUT(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .stall         (stall),
        .imem_rd       (imem_rd),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .exec_start    (exec_start),
        .exec_op       (exec_op),
        .exec_done     (exec_done),
        .exec_zero     (exec_zero),
        .branch        (branch),
        .branchaddress (branchaddress),
        .done          (done),
        .halted        (halted),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous imem and program counter.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
        if (rst) begin
            if (pc_init_en) pc <= pc_init;
        end else if (branch) begin
            pc <= branchaddress;
        end else if (done) begin
            pc <= pc + 8'd1;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h0000;   // NOP
        mem[8'h01] = 16'h103C;   // JMP 0x3C
        mem[8'h3C] = 16'h5000;   // EXEC op 5
        mem[8'h3D] = 16'h2080;   // BZ 0x80
        mem[8'h80] = 16'h6000;   // EXEC op 6
        mem[8'h81] = 16'h2090;   // BZ 0x90
        mem[8'h82] = 16'h0000;   // NOP (stalled fetch)
        mem[8'h83] = 16'h7000;   // EXEC op 7
        mem[8'h90] = 16'h3000;   // HALT
        mem[8'hFF] = 16'h0000;   // NOP at wrap point

        rst = 1'b1; stall = 1'b0; exec_done = 1'b0; exec_zero = 1'b0;
        imem_data = 16'h0000; pc = 8'h00; pc_init = 8'h00; pc_init_en = 1'b1;
        tick(); tick();

        chk("rst_imem_rd", {15'd0, imem_rd}, 16'd0);
        chk("rst_imem_addr", {8'd0, imem_addr}, 16'd0);
        chk("rst_exec_start", {15'd0, exec_start}, 16'd0);
        chk("rst_exec_op", {12'd0, exec_op}, 16'd0);
        chk("rst_branch", {15'd0, branch}, 16'd0);
        chk("rst_branchaddress", {8'd0, branchaddress}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_fault", {15'd0, fault}, 16'd0);

        // NOP at 0x00
        rst = 1'b0; #1;
        chk("nop_fetch_rd", {15'd0, imem_rd}, 16'd1);
        chk("nop_fetch_addr", {8'd0, imem_addr}, 16'h00);
        tick();
        chk("nop_wait_rd", {15'd0, imem_rd}, 16'd0);
        tick();
        chk("nop_dispatch_done", {15'd0, done}, 16'd0);
        tick();
        chk("nop_commit_done", {15'd0, done}, 16'd1);
        chk("nop_commit_branch", {15'd0, branch}, 16'd0);
        tick();
        chk("jmp_fetch_addr", {8'd0, imem_addr}, 16'h01);

        // JMP 0x3C
        tick(); tick(); tick();
        chk("jmp_branch", {15'd0, branch}, 16'd1);
        chk("jmp_branchaddress", {8'd0, branchaddress}, 16'h3C);
        chk("jmp_done", {15'd0, done}, 16'd0);
        tick();
        chk("exec5_fetch_addr", {8'd0, imem_addr}, 16'h3C);

        // EXEC op 5, completes with zero=1 after 3 EXEC cycles
        tick(); tick();
        chk("exec5_start", {15'd0, exec_start}, 16'd1);
        chk("exec5_op_dispatch", {12'd0, exec_op}, 16'd5);
        tick();
        chk("exec5_start_pulse", {15'd0, exec_start}, 16'd0);
        chk("exec5_op_held", {12'd0, exec_op}, 16'd5);
        tick(); tick();
        exec_done = 1'b1; exec_zero = 1'b1;
        tick();
        exec_done = 1'b0; exec_zero = 1'b0;
        chk("exec5_commit_done", {15'd0, done}, 16'd1);
        chk("exec5_commit_branch", {15'd0, branch}, 16'd0);
        tick();
        chk("bz1_fetch_addr", {8'd0, imem_addr}, 16'h3D);

        // BZ 0x80 with zero flag set
        tick(); tick(); tick();
        chk("bz1_branch", {15'd0, branch}, 16'd1);
        chk("bz1_branchaddress", {8'd0, branchaddress}, 16'h80);
        chk("bz1_done", {15'd0, done}, 16'd0);
        tick();
        chk("exec6_fetch_addr", {8'd0, imem_addr}, 16'h80);

        // EXEC op 6, completes with zero=0 in first EXEC cycle
        tick(); tick();
        chk("exec6_op", {12'd0, exec_op}, 16'd6);
        tick();
        exec_done = 1'b1; exec_zero = 1'b0;
        tick();
        exec_done = 1'b0;
        chk("exec6_commit_done", {15'd0, done}, 16'd1);
        tick();
        chk("bz2_fetch_addr", {8'd0, imem_addr}, 16'h81);

        // BZ 0x90 with zero flag clear -> falls through
        tick(); tick(); tick();
        chk("bz2_done", {15'd0, done}, 16'd1);
        chk("bz2_branch", {15'd0, branch}, 16'd0);
        chk("bz2_branchaddress", {8'd0, branchaddress}, 16'h00);
        tick();

        // Stall in FETCH for 5 cycles
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_rd", {15'd0, imem_rd}, 16'd0);
            tick();
        end
        stall = 1'b0; #1;
        chk("stall_release_rd", {15'd0, imem_rd}, 16'd1);
        chk("stall_release_addr", {8'd0, imem_addr}, 16'h82);
        tick();
        stall = 1'b1;   // ignored outside FETCH
        tick(); tick();
        chk("stall_ignored_done", {15'd0, done}, 16'd1);
        stall = 1'b0;
        tick();
        chk("exec7_fetch_addr", {8'd0, imem_addr}, 16'h83);

        // EXEC op 7 aborted by reset mid-EXEC
        tick(); tick(); tick(); tick();
        chk("abort_exec_op_before", {12'd0, exec_op}, 16'd7);
        pc_init_en = 1'b0;
        rst = 1'b1; #1;
        chk("abort_exec_op", {12'd0, exec_op}, 16'd0);
        chk("abort_imem_rd", {15'd0, imem_rd}, 16'd0);
        chk("abort_done", {15'd0, done}, 16'd0);
        tick();
        rst = 1'b0; #1;
        chk("abort_refetch_rd", {15'd0, imem_rd}, 16'd1);
        chk("abort_refetch_addr", {8'd0, imem_addr}, 16'h83);

        // Re-run op 7, never completes -> timeout after 64 EXEC cycles
        tick(); tick(); tick();
        saw_pulse = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            if (done || branch) saw_pulse = 1'b1;
            if (k == 64) begin
                chk("tmo_last_exec_fault", {15'd0, fault}, 16'd0);
                chk("tmo_last_exec_halted", {15'd0, halted}, 16'd0);
            end
            tick();
        end
        chk("tmo_fault", {15'd0, fault}, 16'd1);
        chk("tmo_halted", {15'd0, halted}, 16'd1);
        for (int i = 0; i < 4; i++) begin
            exec_done = 1'b1;   // ignored outside EXEC
            if (done || branch || imem_rd) saw_pulse = 1'b1;
            tick();
        end
        exec_done = 1'b0;
        chk("tmo_no_pulses", {15'd0, saw_pulse}, 16'd0);
        chk("tmo_fault_persist", {15'd0, fault}, 16'd1);

        // Reset clears fault; HALT at 0x90
        pc_init = 8'h90; pc_init_en = 1'b1;
        rst = 1'b1;
        tick();
        chk("rst2_fault", {15'd0, fault}, 16'd0);
        chk("rst2_halted", {15'd0, halted}, 16'd0);
        rst = 1'b0; #1;
        chk("halt_fetch_addr", {8'd0, imem_addr}, 16'h90);
        tick(); tick(); tick();
        chk("halt_halted", {15'd0, halted}, 16'd1);
        chk("halt_fault", {15'd0, fault}, 16'd0);
        saw_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done || branch || imem_rd) saw_pulse = 1'b1;
            tick();
        end
        chk("halt_no_pulses", {15'd0, saw_pulse}, 16'd0);

        // pc wrap: NOP at 0xFF, next fetch from 0x00
        pc_init = 8'hFF;
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        chk("wrap_fetch_ff", {8'd0, imem_addr}, 16'hFF);
        tick(); tick(); tick();
        chk("wrap_done", {15'd0, done}, 16'd1);
        tick();
        chk("wrap_fetch_00_rd", {15'd0, imem_rd}, 16'd1);
        chk("wrap_fetch_00_addr", {8'd0, imem_addr}, 16'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
